// File: rtl/multi_cycle_control_fsm.sv
// Main sequencer of the multi-cycle RV32I CPU: walks IF/ID/EX/MEM/WB and drives the datapath
// controls, memory handshake with timeout, and the sticky ECALL/timeout halt.
module multi_cycle_control_fsm #(
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               alu_bcond,
    input  logic               is_halt_ecall,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         wb_sel,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               is_halted,
    output logic               mem_fault,
    output logic [STATE_W-1:0] dbg_state
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [STATE_W-1:0] S_IF    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_ID    = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_EX    = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_EX_BR = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEM   = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_WB    = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_JUMP  = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_PC4   = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_HALT  = STATE_W'(8);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               fault_q, fault_d;
    logic               mem_wait;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    // Counter only survives while stalled in IF/MEM, so any entry into those states sees zero.
    always_comb begin
        mem_wait = 1'b0;
        wait_d   = '0;
        fault_d  = fault_q;
        if ((state_q == S_IF || state_q == S_MEM) && !mem_ready) begin
            mem_wait = 1'b1;
            if (wait_q != WAIT_LAST) begin
                wait_d = wait_q + WAIT_W'(1);
            end else begin
                fault_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        pc_source = 1'b0;
        i_or_d    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = 2'b00;
        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_ID;
                end else if (mem_wait && fault_d && !fault_q) begin
                    state_d = S_HALT;
                end
            end
            S_ID: begin
                alu_src_b = 2'd2;
                if (is_halt_ecall) begin
                    state_d = S_HALT;
                end else begin
                    case (opcode)
                        OP_R, OP_I, OP_LOAD, OP_STORE, OP_JALR: state_d = S_EX;
                        OP_BRANCH:                              state_d = S_EX_BR;
                        OP_JAL:                                 state_d = S_JUMP;
                        default:                                state_d = S_PC4;
                    endcase
                end
            end
            S_EX: begin
                alu_src_a = 1'b1;
                case (opcode)
                    OP_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    OP_I: begin
                        alu_src_b = 2'd2;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = 2'd2;
                        state_d   = S_MEM;
                    end
                    OP_JALR: begin
                        alu_src_b = 2'd2;
                        state_d   = S_JUMP;
                    end
                    default: state_d = S_PC4;
                endcase
            end
            S_EX_BR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                if (alu_bcond) begin
                    pc_write  = 1'b1;
                    pc_source = 1'b1;
                    state_d   = S_IF;
                end else begin
                    state_d = S_PC4;
                end
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
                if (mem_ready) begin
                    state_d = (opcode == OP_LOAD) ? S_WB : S_PC4;
                end else if (mem_wait && fault_d && !fault_q) begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
                state_d   = S_PC4;
            end
            S_JUMP: begin
                alu_src_b = 2'd1;
                reg_write = 1'b1;
                wb_sel    = 2'd2;
                pc_write  = 1'b1;
                pc_source = 1'b1;
                state_d   = S_IF;
            end
            S_PC4: begin
                alu_src_b = 2'd1;
                pc_write  = 1'b1;
                state_d   = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
        // The register is already back in IF during reset; keep memory and all enables quiet.
        if (reset) begin
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign is_halted = (state_q == S_HALT);
    assign mem_fault = fault_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Randomized scoreboard bench: a per-instruction phase model produces the expected control vector
// for every cycle; a monitor compares each cycle's outputs against the queued expectation.
module tb_multi_cycle_control_fsm;

    localparam int unsigned T = 6;

    localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EX = 4'd2, S_EX_BR = 4'd3, S_MEM = 4'd4;
    localparam logic [3:0] S_WB = 4'd5, S_JUMP = 4'd6, S_PC4 = 4'd7, S_HALT = 4'd8;

    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JAL = 5, K_JALR = 6;
    localparam int K_UNK = 7, K_ECALL = 8;

    typedef struct packed {
        logic        rst;
        logic [6:0]  opc;
        logic        rdy;
        logic        bc;
        logic        hlt;
        logic [19:0] exp;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] opcode = '0;
    logic alu_bcond = 1'b0, is_halt_ecall = 1'b0, mem_ready = 1'b0;
    logic pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] wb_sel, alu_src_b, alu_op;
    logic alu_src_a, is_halted, mem_fault;
    logic [3:0] dbg_state;

    multi_cycle_control_fsm #(.STATE_W(4), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond),
        .is_halt_ecall(is_halt_ecall), .mem_ready(mem_ready), .pc_write(pc_write),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted), .mem_fault(mem_fault),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    step_t       plan[$];
    logic [19:0] sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic        m_halted = 1'b0;
    logic        m_fault = 1'b0;

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom);
    endfunction

    function automatic logic [6:0] opc_of(int kind);
        logic [6:0] unk[5];
        unk = '{7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011, 7'b0000000};
        case (kind)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LOAD:  return 7'b0000011;
            K_STORE: return 7'b0100011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            K_ECALL: return 7'b1110011;
            default: return unk[$urandom_range(0, 4)];
        endcase
    endfunction

    function automatic logic [19:0] ov(logic [3:0] st, logic pcw, logic pcs, logic iod, logic mr,
                                       logic mw, logic irw, logic rw, logic [1:0] wbs, logic sa,
                                       logic [1:0] sb, logic [1:0] aop);
        return {pcw, pcs, iod, mr, mw, irw, rw, wbs, sa, sb, aop, m_halted, m_fault, st};
    endfunction

    task automatic add(logic rst, logic [6:0] opc, logic rdy, logic bc, logic hlt, logic [19:0] e);
        step_t s;
        s.rst = rst; s.opc = opc; s.rdy = rdy; s.bc = bc; s.hlt = hlt; s.exp = e;
        plan.push_back(s);
    endtask

    task automatic rst_step();
        m_halted = 1'b0;
        m_fault  = 1'b0;
        add(1'b1, r7(), r1(), r1(), r1(), ov(S_IF, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0));
    endtask

    task automatic halt_tail();
        for (int i = 0; i < 3; i++)
            add(1'b0, r7(), r1(), r1(), r1(), ov(S_HALT, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0));
        rst_step();
    endtask

    // Memory phase: wmem stall cycles, optional reset after rst_at of them; returns 1 if aborted.
    task automatic mem_phase(logic [6:0] opc, logic ld, int wmem, int rst_at, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < wmem && i < int'(T); i++) begin
            if (i == rst_at) begin
                rst_step();
                ab = 1'b1;
                return;
            end
            add(1'b0, opc, 1'b0, r1(), r1(), ov(S_MEM, 0, 0, 1, ld, !ld, 0, 0, 2'd0, 0, 2'd0, 2'd0));
        end
        if (wmem >= int'(T)) begin
            m_fault  = 1'b1;
            m_halted = 1'b1;
            halt_tail();
            ab = 1'b1;
            return;
        end
        add(1'b0, opc, 1'b1, r1(), r1(), ov(S_MEM, 0, 0, 1, ld, !ld, 0, 0, 2'd0, 0, 2'd0, 2'd0));
    endtask

    task automatic do_instr(int kind, int wif, int wmem, logic bc, int rst_at);
        logic [6:0] opc;
        bit ab;
        opc = opc_of(kind);
        for (int i = 0; i < wif && i < int'(T); i++)
            add(1'b0, r7(), 1'b0, r1(), r1(), ov(S_IF, 0, 0, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0));
        if (wif >= int'(T)) begin
            m_fault  = 1'b1;
            m_halted = 1'b1;
            halt_tail();
            return;
        end
        add(1'b0, r7(), 1'b1, r1(), r1(), ov(S_IF, 0, 0, 0, 1, 0, 1, 0, 2'd0, 0, 2'd0, 2'd0));
        add(1'b0, opc, r1(), r1(), kind == K_ECALL,
            ov(S_ID, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 2'b00));
        case (kind)
            K_R, K_I: begin
                add(1'b0, opc, r1(), r1(), r1(), ov(S_EX, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1,
                                                    (kind == K_I) ? 2'd2 : 2'd0, 2'b10));
                add(1'b0, opc, r1(), r1(), r1(), ov(S_WB, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 2'd0));
            end
            K_LOAD, K_STORE: begin
                add(1'b0, opc, r1(), r1(), r1(), ov(S_EX, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'b00));
                mem_phase(opc, kind == K_LOAD, wmem, rst_at, ab);
                if (ab) return;
                if (kind == K_LOAD)
                    add(1'b0, opc, r1(), r1(), r1(), ov(S_WB, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0));
            end
            K_BR: begin
                add(1'b0, opc, r1(), bc, r1(), ov(S_EX_BR, bc, bc, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'b01));
                if (bc) return;
            end
            K_JAL, K_JALR: begin
                if (kind == K_JALR)
                    add(1'b0, opc, r1(), r1(), r1(), ov(S_EX, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'b00));
                add(1'b0, opc, r1(), r1(), r1(), ov(S_JUMP, 1, 1, 0, 0, 0, 0, 1, 2'd2, 0, 2'd1, 2'b00));
                return;
            end
            K_ECALL: begin
                m_halted = 1'b1;
                halt_tail();
                return;
            end
            default: ;
        endcase
        add(1'b0, opc, r1(), r1(), r1(), ov(S_PC4, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'b00));
    endtask

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    initial begin
        logic [19:0] act, e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
                       wb_sel, alu_src_a, alu_src_b, alu_op, is_halted, mem_fault, dbg_state};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL ctrl_vec t=%0t got=%05h expected=%05h", $time, act, e);
                end
            end
        end
    end

    initial begin
        int kind;
        int guard;
        step_t s;
        rst_step();
        rst_step();
        do_instr(K_R, 2, 0, 1'b0, -1);
        do_instr(K_LOAD, 0, 0, 1'b0, -1);
        do_instr(K_BR, 0, 0, 1'b1, -1);
        do_instr(K_BR, 1, 0, 1'b0, -1);
        do_instr(K_JALR, 0, 0, 1'b0, -1);
        do_instr(K_STORE, 0, 3, 1'b0, -1);
        do_instr(K_JAL, 0, 0, 1'b0, -1);
        do_instr(K_UNK, 0, 0, 1'b0, -1);
        do_instr(K_I, 0, 0, 1'b0, -1);
        do_instr(K_ECALL, 0, 0, 1'b0, -1);
        do_instr(K_STORE, 0, 4, 1'b0, 2);
        do_instr(K_LOAD, int'(T) - 1, int'(T) - 1, 1'b0, -1);
        do_instr(K_R, 0, 0, 1'b0, -1);
        do_instr(K_LOAD, 0, int'(T), 1'b0, -1);
        do_instr(K_STORE, int'(T), 0, 1'b0, -1);
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 7);
            if ($urandom_range(0, 24) == 0) kind = K_ECALL;
            do_instr(kind, $urandom_range(0, 3), $urandom_range(0, 3), r1(),
                     ($urandom_range(0, 19) == 0) ? 0 : -1);
        end
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(posedge clk);
            #1;
            reset = s.rst;
            opcode = s.opc;
            mem_ready = s.rdy;
            alu_bcond = s.bc;
            is_halt_ecall = s.hlt;
            sb_q.push_back(s.exp);
        end
        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
